unified_mem_arbiter: RTL and testbench

Shares one single-port unified instruction/data memory between the pipelined core's fetch port (I) and its load/store port (D). Grants one transaction at a time. Data has priority, with a streak limit so fetch is not starved. Produces per-port ack, read data and stall for the core's hazard logic. Honours branch/jump flushes of an in-flight fetch. Sits between the core datapath and the memory model/controller.

---
 rtl/mem_arb_pkg.sv | 15 +
 rtl/unified_mem_arbiter.sv | 172 +++++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified instruction/data memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        I_WAIT,
        D_WAIT
    } arb_state_t;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    localparam int unsigned STREAK_W = 4;

endpackage

// File: rtl/unified_mem_arbiter.sv
// Arbitrates the core's fetch (I) and load/store (D) ports onto one single-port memory.
// Data has priority, bounded by a streak limit so a pending fetch cannot starve.
module unified_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW           = 32,
    parameter int unsigned DW           = 32,
    parameter int unsigned MAX_D_STREAK = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    input  logic          i_flush,
    output logic [DW-1:0] i_rdata,
    output logic          i_ack,
    output logic          i_stall,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ack,
    output logic          d_stall,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack
);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

    arb_state_t          stateQ, stateD;
    logic [STREAK_W-1:0] streakQ, streakD;
    logic                cancelQ, cancelD;
    logic                memReqQ, memReqD;
    logic                memWeQ, memWeD;
    logic [AW-1:0]       memAddrQ, memAddrD;
    logic [DW-1:0]       memWdataQ, memWdataD;
    logic                iAckQ, iAckD;
    logic                dAckQ, dAckD;
    logic [DW-1:0]       iRdataQ, iRdataD;
    logic [DW-1:0]       dRdataQ, dRdataD;

    logic iElig, dElig, grantValid, grantOwner;

    // A port whose ack is showing this cycle has not yet had a chance to drop its request.
    assign iElig = i_req & ~iAckQ & ~i_flush;
    assign dElig = d_req & ~dAckQ;

    always_comb begin
        grantValid = 1'b0;
        grantOwner = OWN_I;
        if (dElig && !((streakQ == STREAK_MAX) && iElig)) begin
            grantValid = 1'b1;
            grantOwner = OWN_D;
        end else if (iElig) begin
            grantValid = 1'b1;
            grantOwner = OWN_I;
        end
    end

    always_comb begin
        stateD    = stateQ;
        streakD   = streakQ;
        cancelD   = cancelQ;
        memReqD   = memReqQ;
        memWeD    = memWeQ;
        memAddrD  = memAddrQ;
        memWdataD = memWdataQ;
        iAckD     = 1'b0;
        dAckD     = 1'b0;
        iRdataD   = iRdataQ;
        dRdataD   = dRdataQ;

        unique case (stateQ)
            IDLE: begin
                if (grantValid) begin
                    memReqD = 1'b1;
                    if (grantOwner == OWN_D) begin
                        stateD    = D_WAIT;
                        memWeD    = d_we;
                        memAddrD  = d_addr;
                        memWdataD = d_wdata;
                        // Saturate at the limit so the forced-fetch condition stays reachable.
                        if (!i_req) begin
                            streakD = '0;
                        end else if (streakQ != STREAK_MAX) begin
                            streakD = streakQ + STREAK_W'(1);
                        end
                    end else begin
                        stateD    = I_WAIT;
                        memWeD    = 1'b0;
                        memAddrD  = i_addr;
                        memWdataD = '0;
                        streakD   = '0;
                    end
                end else if (!i_req) begin
                    streakD = '0;
                end
            end
            I_WAIT: begin
                if (mem_ack) begin
                    stateD  = IDLE;
                    memReqD = 1'b0;
                    memWeD  = 1'b0;
                    cancelD = 1'b0;
                    if (!(cancelQ || i_flush)) begin
                        iAckD   = 1'b1;
                        iRdataD = mem_rdata;
                    end
                end else if (i_flush) begin
                    cancelD = 1'b1;
                end
            end
            D_WAIT: begin
                if (mem_ack) begin
                    stateD  = IDLE;
                    memReqD = 1'b0;
                    memWeD  = 1'b0;
                    dAckD   = 1'b1;
                    if (!memWeQ) begin
                        dRdataD = mem_rdata;
                    end
                end
            end
            default: stateD = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateQ    <= IDLE;
            streakQ   <= '0;
            cancelQ   <= 1'b0;
            memReqQ   <= 1'b0;
            memWeQ    <= 1'b0;
            memAddrQ  <= '0;
            memWdataQ <= '0;
            iAckQ     <= 1'b0;
            dAckQ     <= 1'b0;
            iRdataQ   <= '0;
            dRdataQ   <= '0;
        end else begin
            stateQ    <= stateD;
            streakQ   <= streakD;
            cancelQ   <= cancelD;
            memReqQ   <= memReqD;
            memWeQ    <= memWeD;
            memAddrQ  <= memAddrD;
            memWdataQ <= memWdataD;
            iAckQ     <= iAckD;
            dAckQ     <= dAckD;
            iRdataQ   <= iRdataD;
            dRdataQ   <= dRdataD;
        end
    end

    assign mem_req   = memReqQ;
    assign mem_we    = memWeQ;
    assign mem_addr  = memAddrQ;
    assign mem_wdata = memWdataQ;
    assign i_ack     = iAckQ;
    assign d_ack     = dAckQ;
    assign i_rdata   = iRdataQ;
    assign d_rdata   = dRdataQ;
    assign i_stall   = i_req & ~iAckQ;
    assign d_stall   = d_req & ~dAckQ;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench for unified_mem_arbiter: directed transactions, expected grants and
// read data queued at issue time and checked by an independent monitor.
module tb_unified_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, i_flush, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        i_ack, i_stall, d_ack, d_stall, mem_req, mem_we;
    logic        backendAck, lateAck;
    wire         mem_ack;

    assign mem_ack = backendAck | lateAck;

    always #5 clk = ~clk;

    unified_mem_arbiter #(
        .AW(32),
        .DW(32),
        .MAX_D_STREAK(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_flush  (i_flush),
        .i_rdata  (i_rdata),
        .i_ack    (i_ack),
        .i_stall  (i_stall),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_rdata  (d_rdata),
        .d_ack    (d_ack),
        .d_stall  (d_stall),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ack  (mem_ack)
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } grant_t;

    grant_t      grantQ[$];
    logic [31:0] iQ[$];
    logic [31:0] dQ[$];
    logic [31:0] memModel[logic [31:0]];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int iAckCount = 0;
    int dAckCount = 0;
    int memLat = 1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pushGrant(input logic [31:0] a, input logic we, input logic [31:0] wd);
        grant_t g;
        g.addr  = a;
        g.we    = we;
        g.wdata = wd;
        grantQ.push_back(g);
    endtask

    task automatic waitCycle();
        @(posedge clk);
        #1;
    endtask

    // which: 0 = i_ack, 1 = d_ack, 2 = mem_req
    task automatic waitEv(input int which, input string name);
        int n = 0;
        bit hit = 1'b0;
        while (!hit && n < 50) begin
            waitCycle();
            n++;
            hit = (which == 0) ? i_ack : (which == 1) ? d_ack : mem_req;
        end
        if (!hit) begin
            checks++;
            errors++;
            $display("FAIL %s: got no event expected one within 50 cycles", name);
        end
    endtask

    // Backend memory model with programmable latency counted from the first mem_req cycle.
    initial begin
        int waitCnt = 0;
        backendAck = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(posedge clk);
            #1;
            backendAck = 1'b0;
            if (mem_req) begin
                waitCnt++;
                if (waitCnt >= memLat) begin
                    backendAck = 1'b1;
                    waitCnt    = 0;
                    if (mem_we) memModel[mem_addr] = mem_wdata;
                    else mem_rdata = memModel.exists(mem_addr) ? memModel[mem_addr] : 32'h0;
                end
            end else begin
                waitCnt = 0;
            end
        end
    end

    // Monitor: compares every grant and every ack against the queued expectations.
    initial begin
        grant_t g;
        logic   memReqPrev = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_req && !memReqPrev) begin
                if (grantQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_grant: got addr %h expected no grant", mem_addr);
                end else begin
                    g = grantQ.pop_front();
                    check("grant_addr", mem_addr, g.addr);
                    check("grant_we", 32'(mem_we), 32'(g.we));
                    if (g.we) check("grant_wdata", mem_wdata, g.wdata);
                end
            end
            memReqPrev = mem_req;
            if (i_ack) begin
                iAckCount++;
                if (iQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_i_ack: got i_ack data %h expected no ack", i_rdata);
                end else begin
                    check("i_rdata", i_rdata, iQ.pop_front());
                end
            end
            if (d_ack) begin
                dAckCount++;
                if (dQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_d_ack: got d_ack data %h expected no ack", d_rdata);
                end else begin
                    check("d_rdata", d_rdata, dQ.pop_front());
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, dAckCyc, iAckCyc, acksBefore;
        reset = 1'b1;  lateAck = 1'b0;
        i_req = 1'b0;  i_flush = 1'b0; i_addr = '0;
        d_req = 1'b0;  d_we = 1'b0;    d_addr = '0; d_wdata = '0;
        memModel[32'h40]  = 32'h2008_0005;
        memModel[32'h44]  = 32'h00A0_0013;
        memModel[32'h48]  = 32'h4848_4848;
        memModel[32'h84]  = 32'h0000_00FF;
        memModel[32'h90]  = 32'h9090_9090;
        memModel[32'h100] = 32'h1234_5678;
        memModel[32'h200] = 32'hCAFE_0001;
        repeat (2) waitCycle();

        // Reset values
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_acks", 32'({i_ack, d_ack}), 32'd0);
        check("rst_i_rdata", i_rdata, 32'h0);
        check("rst_d_rdata", d_rdata, 32'h0);
        reset = 1'b0;
        waitCycle();

        // Single fetch, 1-cycle backend
        pushGrant(32'h40, 1'b0, 32'h0);
        iQ.push_back(32'h2008_0005);
        i_req = 1'b1; i_addr = 32'h40; t0 = cyc;
        #1 check("t1_stall_t", 32'(i_stall), 32'd1);
        waitCycle();
        check("t1_mem_req", 32'(mem_req), 32'd1);
        check("t1_stall_t1", 32'(i_stall), 32'd1);
        check("t1_no_ack_t1", 32'(i_ack), 32'd0);
        waitCycle();
        check("t1_ack_t2", 32'(i_ack), 32'd1);
        check("t1_stall_t2", 32'(i_stall), 32'd0);
        check("t1_latency", cyc - t0, 32'd2);
        i_req = 1'b0;
        waitCycle();

        // Simultaneous: store wins, fetch granted in d_ack cycle
        pushGrant(32'h80, 1'b1, 32'hDEAD_BEEF);
        pushGrant(32'h44, 1'b0, 32'h0);
        dQ.push_back(32'h0);
        iQ.push_back(32'h00A0_0013);
        i_req = 1'b1; i_addr = 32'h44;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'hDEAD_BEEF;
        fork
            begin waitEv(1, "t2_d_ack"); dAckCyc = cyc; d_req = 1'b0; end
            begin waitEv(0, "t2_i_ack"); iAckCyc = cyc; i_req = 1'b0; end
        join
        check("t2_ack_gap", iAckCyc - dAckCyc, 32'd2);
        d_we = 1'b0;
        waitCycle();

        // Flush during I_WAIT suppresses the ack and keeps old fetch data
        memLat = 3;
        pushGrant(32'h100, 1'b0, 32'h0);
        i_req = 1'b1; i_addr = 32'h100;
        waitEv(2, "t3_grant");
        i_flush = 1'b1;
        waitCycle();
        i_flush = 1'b0; i_req = 1'b0;
        acksBefore = iAckCount;
        repeat (5) waitCycle();
        check("t3_no_i_ack", iAckCount, acksBefore);
        check("t3_i_rdata_hold", i_rdata, 32'h00A0_0013);
        check("t3_mem_idle", 32'(mem_req), 32'd0);
        memLat = 1;
        pushGrant(32'h200, 1'b0, 32'h0);
        iQ.push_back(32'hCAFE_0001);
        i_req = 1'b1; i_addr = 32'h200;
        waitEv(0, "t3_refetch");
        i_req = 1'b0;
        check("t3_refetch_data", i_rdata, 32'hCAFE_0001);
        waitCycle();

        // Load data held across a following store
        pushGrant(32'h84, 1'b0, 32'h0);
        dQ.push_back(32'h0000_00FF);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h84;
        waitEv(1, "t4_load");
        d_req = 1'b0;
        waitCycle();
        pushGrant(32'h88, 1'b1, 32'h55);
        dQ.push_back(32'h0000_00FF);
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h88; d_wdata = 32'h55;
        waitEv(1, "t4_store");
        d_req = 1'b0; d_we = 1'b0;
        waitCycle();
        check("t4_d_rdata_hold", d_rdata, 32'h0000_00FF);

        // Streak limit: fetch held but flushed during four loads, then released with
        // both ports eligible; the fetch must win, then data resumes.
        for (int k = 0; k < 4; k++) pushGrant(32'h90, 1'b0, 32'h0);
        pushGrant(32'h48, 1'b0, 32'h0);
        pushGrant(32'h90, 1'b0, 32'h0);
        for (int k = 0; k < 5; k++) dQ.push_back(32'h9090_9090);
        iQ.push_back(32'h4848_4848);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h90;
        i_req = 1'b1; i_addr = 32'h48; i_flush = 1'b1;
        for (int k = 0; k < 4; k++) waitEv(1, "t5_d_streak");
        waitCycle();
        i_flush = 1'b0;
        waitEv(0, "t5_forced_i");
        i_req = 1'b0;
        waitEv(1, "t5_d_after_i");
        d_req = 1'b0;
        waitCycle();

        // Reset mid-transaction drops mem_req asynchronously; late ack is ignored
        memLat = 3;
        pushGrant(32'h300, 1'b0, 32'h0);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
        waitEv(2, "t6_grant");
        waitCycle();
        #2 reset = 1'b1;
        #1;
        check("t6_mem_req_async", 32'(mem_req), 32'd0);
        check("t6_mem_addr", mem_addr, 32'h0);
        check("t6_i_rdata", i_rdata, 32'h0);
        check("t6_d_rdata", d_rdata, 32'h0);
        d_req = 1'b0;
        acksBefore = dAckCount;
        waitCycle();
        reset = 1'b0;
        lateAck = 1'b1;
        waitCycle();
        lateAck = 1'b0;
        check("t6_no_d_ack", 32'(d_ack), 32'd0);
        check("t6_no_mem_req", 32'(mem_req), 32'd0);
        repeat (2) waitCycle();
        check("t6_d_ack_count", dAckCount, acksBefore);
        memLat = 1;

        check("queues_empty", grantQ.size() + iQ.size() + dQ.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
